// File: rtl/wdt_pkg.sv
// Shared types and helpers for the multi-channel windowed watchdog.
package wdt_pkg;

  // Per-channel watchdog state; encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLOSED = 2'd1,
    ST_OPEN   = 2'd2,
    ST_FAULT  = 2'd3
  } wdt_state_t;

  // Bit positions inside the per-channel cause register.
  localparam int CAUSE_EARLY   = 0;
  localparam int CAUSE_TIMEOUT = 1;
  localparam int CAUSE_W       = 2;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: window FSM, cycle counter, stored bounds, sticky causes.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int WARN_MARGIN = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cfg_wr_i,
  input  logic [CNT_W-1:0] cfg_lo_i,
  input  logic [CNT_W-1:0] cfg_hi_i,
  input  logic             kick_i,
  input  logic             clr_i,
  output logic             armed_o,
  output logic             warn_o,
  output logic             fault_o,
  output logic             early_err_o,
  output logic             timeout_err_o,
  output logic             fault_set_o,
  output logic [1:0]       state_o
);

  wdt_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   hi_q, hi_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CNT_W:0]     warn_cnt;

  // Next-state: accepted config write > clear > counting/kick (only while enabled).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cause_d = cause_q;
    if (cfg_wr_i) begin
      lo_d    = cfg_lo_i;
      hi_d    = cfg_hi_i;
      cnt_d   = '0;
      cause_d = '0;
      state_d = (cfg_lo_i == '0) ? ST_OPEN : ST_CLOSED;
    end else if (clr_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      cause_d = '0;
    end else if (en_i) begin
      case (state_q)
        ST_CLOSED: begin
          if (kick_i) begin
            state_d              = ST_FAULT;
            cause_d[CAUSE_EARLY] = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == lo_q) state_d = ST_OPEN;
          end
        end
        ST_OPEN: begin
          // A kick on the last window cycle still counts as a valid service.
          if (kick_i) begin
            cnt_d   = '0;
            state_d = (lo_q == '0) ? ST_OPEN : ST_CLOSED;
          end else if (cnt_q == hi_q - 1'b1) begin
            state_d                = ST_FAULT;
            cause_d[CAUSE_TIMEOUT] = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter, bounds and causes register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cause_q <= cause_d;
    end
  end

  // Widened add avoids underflow when win_hi is smaller than the margin.
  assign warn_cnt      = {1'b0, cnt_q} + (CNT_W+1)'(WARN_MARGIN);
  assign warn_o        = (state_q == ST_OPEN) && (warn_cnt >= {1'b0, hi_q});
  assign armed_o       = (state_q == ST_CLOSED) || (state_q == ST_OPEN);
  assign fault_o       = (state_q == ST_FAULT);
  assign early_err_o   = cause_q[CAUSE_EARLY];
  assign timeout_err_o = cause_q[CAUSE_TIMEOUT];
  assign fault_set_o   = (state_d == ST_FAULT) && (state_q != ST_FAULT);
  assign state_o       = state_q;

endmodule

// File: rtl/wdt_window_multi.sv
// Multi-channel windowed watchdog: config decode, reject pulse, shared reset request.
module wdt_window_multi
  import wdt_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int WARN_MARGIN = 8,
  parameter int RST_LEN     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               cfg_we,
  input  logic [wdt_pkg::ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]                   cfg_win_lo,
  input  logic [CNT_W-1:0]                   cfg_win_hi,
  output logic                               cfg_err,
  input  logic [NUM_CH-1:0]                  kick,
  input  logic [NUM_CH-1:0]                  clr,
  output logic [NUM_CH-1:0]                  armed,
  output logic [NUM_CH-1:0]                  warn,
  output logic [NUM_CH-1:0]                  fault,
  output logic [NUM_CH-1:0]                  early_err,
  output logic [NUM_CH-1:0]                  timeout_err,
  output logic                               sys_rst_req,
  output logic [2*NUM_CH-1:0]                dbg_state
);

  localparam int RCW = $clog2(RST_LEN + 1);

  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] fault_set;
  logic              ch_ok;
  logic              armed_sel;
  logic              cfg_accept;
  logic              cfg_err_q;
  logic [RCW-1:0]    rst_cnt_q;

  // Config strobe: cfg_we is a single-cycle request with no back-pressure; the
  // write either takes effect at that edge or is answered by a cfg_err pulse
  // on the following cycle. Bounds are locked while the target is armed.
  always_comb begin
    ch_ok     = int'(cfg_ch) < NUM_CH;
    armed_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_ch) == i) armed_sel = armed[i];
    end
    cfg_accept = cfg_we && ch_ok && !armed_sel && (cfg_win_lo < cfg_win_hi);
    ch_wr      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_accept && (int'(cfg_ch) == i)) ch_wr[i] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdt_channel #(
      .CNT_W       (CNT_W),
      .WARN_MARGIN (WARN_MARGIN)
    ) u_ch (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en),
      .cfg_wr_i      (ch_wr[i]),
      .cfg_lo_i      (cfg_win_lo),
      .cfg_hi_i      (cfg_win_hi),
      .kick_i        (kick[i]),
      .clr_i         (clr[i]),
      .armed_o       (armed[i]),
      .warn_o        (warn[i]),
      .fault_o       (fault[i]),
      .early_err_o   (early_err[i]),
      .timeout_err_o (timeout_err[i]),
      .fault_set_o   (fault_set[i]),
      .state_o       (dbg_state[2*i +: 2])
    );
  end

  // Registered one-cycle reject pulse for writes that were not accepted.
  always_ff @(posedge clk) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_we && !cfg_accept;
  end

  // Reset-request pulse counter; any channel entering FAULT reloads it fully,
  // so the request rises on the same edge the fault flag does.
  always_ff @(posedge clk) begin
    if (rst)                  rst_cnt_q <= '0;
    else if (|fault_set)      rst_cnt_q <= RCW'(RST_LEN);
    else if (rst_cnt_q != '0) rst_cnt_q <= rst_cnt_q - 1'b1;
  end

  assign cfg_err     = cfg_err_q;
  assign sys_rst_req = (rst_cnt_q != '0);

endmodule

// File: tb/tb_wdt_window_multi.sv
// Directed bench for the multi-channel windowed watchdog.
module tb_wdt_window_multi;

  localparam logic [1:0] S_IDLE = 2'd0, S_CLOSED = 2'd1, S_OPEN = 2'd2, S_FAULT = 2'd3;

  logic        clk, rst, en, cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_win_lo, cfg_win_hi;
  logic        cfg_err;
  logic [3:0]  kick, clr, armed, warn, fault, early_err, timeout_err;
  logic        sys_rst_req;
  logic [7:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  kick;
    logic [13:0] exp_ctl;  // {cfg_err, armed, fault, warn, sys_rst_req}
    logic [7:0]  exp_st;
  } vec_t;

  vec_t tbl[8];

  wdt_window_multi dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_win_lo(cfg_win_lo), .cfg_win_hi(cfg_win_hi), .cfg_err(cfg_err),
    .kick(kick), .clr(clr), .armed(armed), .warn(warn), .fault(fault),
    .early_err(early_err), .timeout_err(timeout_err),
    .sys_rst_req(sys_rst_req), .dbg_state(dbg_state)
  );

  // Clock and time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_limit: run still active at 100000 ns, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int lo, input int hi);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_win_lo = 16'(lo); cfg_win_hi = 16'(hi);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic kick_ch(input int ch);
    kick[ch] = 1'b1;
    step();
    kick = '0;
  endtask

  task automatic clr_ch(input int ch);
    clr[ch] = 1'b1;
    step();
    clr = '0;
  endtask

  function automatic logic [1:0] st(input int ch);
    return dbg_state[2*ch +: 2];
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    logic [13:0] e;
    rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
    cfg_win_lo = '0; cfg_win_hi = '0; kick = '0; clr = '0;
    step(); step();
    chk("reset_outputs", {cfg_err, armed, warn, fault, early_err, timeout_err, sys_rst_req, dbg_state}, 32'h0);
    rst = 1'b0;

    // Arm ch0, rejected writes (armed target, lo==hi, lo>hi), window open, kick.
    tbl[0] = '{1'b1, 2'd0, 16'd4, 16'd10, 4'h0, {1'b0, 4'h1, 4'h0, 4'h0, 1'b0}, 8'h01};
    tbl[1] = '{1'b1, 2'd0, 16'd2, 16'd8,  4'h0, {1'b1, 4'h1, 4'h0, 4'h0, 1'b0}, 8'h01};
    tbl[2] = '{1'b1, 2'd1, 16'd5, 16'd5,  4'h0, {1'b1, 4'h1, 4'h0, 4'h0, 1'b0}, 8'h01};
    tbl[3] = '{1'b1, 2'd1, 16'd6, 16'd5,  4'h0, {1'b1, 4'h1, 4'h0, 4'h0, 1'b0}, 8'h01};
    tbl[4] = '{1'b0, 2'd0, 16'd0, 16'd0,  4'h0, {1'b0, 4'h1, 4'h0, 4'h1, 1'b0}, 8'h02};
    tbl[5] = '{1'b0, 2'd0, 16'd0, 16'd0,  4'h0, {1'b0, 4'h1, 4'h0, 4'h1, 1'b0}, 8'h02};
    tbl[6] = '{1'b0, 2'd0, 16'd0, 16'd0,  4'h0, {1'b0, 4'h1, 4'h0, 4'h1, 1'b0}, 8'h02};
    tbl[7] = '{1'b0, 2'd0, 16'd0, 16'd0,  4'h1, {1'b0, 4'h1, 4'h0, 4'h0, 1'b0}, 8'h01};
    for (int i = 0; i < 8; i++) begin
      cfg_we = tbl[i].we; cfg_ch = tbl[i].ch;
      cfg_win_lo = tbl[i].lo; cfg_win_hi = tbl[i].hi; kick = tbl[i].kick;
      exp_q.push_back(tbl[i].exp_ctl);
      step();
      cfg_we = 1'b0; kick = '0;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_ctl", i), {cfg_err, armed, fault, warn, sys_rst_req}, e);
      chk($sformatf("vec%0d_state", i), dbg_state, tbl[i].exp_st);
    end

    // Five more in-window kicks at count 6 on ch0.
    for (int r = 0; r < 5; r++) begin
      cycles(6);
      chk($sformatf("ch0_open_r%0d", r), st(0), S_OPEN);
      kick_ch(0);
      chk($sformatf("ch0_closed_r%0d", r), st(0), S_CLOSED);
      chk($sformatf("ch0_nofault_r%0d", r), {fault[0], early_err[0], timeout_err[0]}, 0);
    end
    clr_ch(0);
    chk("ch0_disarm", {armed[0], st(0)}, 0);

    // Early kick on ch1 and reset-request pulse length.
    cfg_write(1, 4, 10);
    cycles(2);
    kick_ch(1);
    chk("ch1_early", {fault[1], early_err[1], timeout_err[1], sys_rst_req}, 4'b1101);
    n = 0;
    while (sys_rst_req && n < 60) begin n++; step(); end
    chk("ch1_rst_len", n, 16);
    clr_ch(1);
    chk("ch1_clr", {fault[1], early_err[1], timeout_err[1], st(1)}, 0);

    // ch2 with lo=0: warn threshold, timeout, then kick on last window cycle.
    cfg_write(2, 0, 10);
    chk("ch2_open_at_arm", {st(2), warn[2]}, {S_OPEN, 1'b0});
    step();
    chk("ch2_warn_cnt1", warn[2], 1'b0);
    step();
    chk("ch2_warn_cnt2", warn[2], 1'b1);
    cycles(7);
    chk("ch2_cnt9_nofault", fault[2], 1'b0);
    step();
    chk("ch2_timeout", {fault[2], timeout_err[2], early_err[2], warn[2]}, 4'b1100);
    clr_ch(2);
    cfg_write(2, 0, 10);
    cycles(9);
    kick_ch(2);
    chk("ch2_last_kick", {fault[2], st(2), warn[2]}, {1'b0, S_OPEN, 1'b0});
    cycles(9);
    chk("ch2_rerun_nofault", fault[2], 1'b0);
    clr_ch(2);
    n = 0;
    while (sys_rst_req && n < 40) begin n++; step(); end
    chk("srr_idle", sys_rst_req, 1'b0);

    // ch0 then ch3 five cycles later: reset request is extended.
    cfg_write(0, 4, 10);
    cfg_write(3, 8, 20);
    kick_ch(0);
    chk("ch0_fault_srr", {fault, sys_rst_req}, 5'b00011);
    n = 0;
    while (sys_rst_req && n < 60) begin
      n++;
      kick[3] = (n == 5);
      step();
      kick = '0;
    end
    chk("srr_extended_len", n, 21);
    chk("two_faults", {fault, early_err}, 8'h99);
    clr[0] = 1'b1; kick[0] = 1'b1;
    step();
    clr = '0; kick = '0;
    chk("ch0_clr_from_fault", {st(0), fault, early_err}, {S_IDLE, 4'h8, 4'h8});
    cfg_write(0, 4, 10);
    clr[0] = 1'b1; kick[0] = 1'b1;
    step();
    clr = '0; kick = '0;
    chk("ch0_clr_beats_kick", {st(0), fault[0], sys_rst_req}, 0);

    // Freeze mid-window, then timeout on the original schedule; then reset.
    cfg_write(1, 4, 10);
    cycles(6);
    en = 1'b0;
    cycles(18);
    cfg_write(2, 3, 9);
    chk("cfg_while_frozen", {armed[2], cfg_err}, 2'b10);
    clr_ch(2);
    chk("clr_while_frozen", armed[2], 1'b0);
    chk("ch1_frozen", {st(1), fault[1]}, {S_OPEN, 1'b0});
    en = 1'b1;
    cycles(3);
    chk("ch1_cnt9_nofault", fault[1], 1'b0);
    step();
    chk("ch1_timeout", {fault[1], timeout_err[1], sys_rst_req}, 3'b111);
    cycles(2);
    rst = 1'b1;
    step();
    chk("rst_abort", {cfg_err, armed, warn, fault, early_err, timeout_err, sys_rst_req, dbg_state}, 32'h0);
    rst = 1'b0;
    step();
    chk("after_rst", {sys_rst_req, fault, armed}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
